win3x3_filter: RTL and testbench

//  3x3 window generator + fixed Gaussian filter stage.

---
 rtl/win3x3_filter.sv | 106 ++++++++++
 tb/tb_win3x3_filter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/win3x3_filter.sv
// 3x3 sliding window over column beats from the three-row line buffer, followed by
// a fixed Gaussian [1 2 1; 2 4 2; 1 2 1] stage producing the raw sum and a rounded /16 pixel.
module win3x3_filter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_in_0,
  input  logic [DATA_WIDTH-1:0]   data_in_1,
  input  logic [DATA_WIDTH-1:0]   data_in_2,
  input  logic                    in_valid,
  output logic [DATA_WIDTH+3:0]   out_sum,
  output logic [DATA_WIDTH-1:0]   out_pix,
  output logic [ADDR_WIDTH-1:0]   out_col,
  output logic                    out_eol,
  output logic                    out_valid
);

  localparam int RW = DATA_WIDTH + 2;
  localparam int SW = DATA_WIDTH + 4;
  localparam int PW = DATA_WIDTH + 5;
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] EOL_COL  = ADDR_WIDTH'(LENGTH - 2);

  logic [ADDR_WIDTH-1:0] col_cnt;
  logic [DATA_WIDTH-1:0] win_l [3];
  logic [DATA_WIDTH-1:0] win_c [3];
  logic [DATA_WIDTH-1:0] win_r [3];
  logic                  win_v;
  logic [ADDR_WIDTH-1:0] win_col;

  logic [RW-1:0]         row_sum [3];
  logic                  s1_v;
  logic [ADDR_WIDTH-1:0] s1_col;

  logic [SW-1:0]         sum_c;
  logic [PW-1:0]         rnd_c;

  // S0: column counter and window shift; windows straddling a line start are never flagged valid
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      win_v   <= 1'b0;
      win_col <= '0;
      for (int i = 0; i < 3; i++) begin
        win_l[i] <= '0;
        win_c[i] <= '0;
        win_r[i] <= '0;
      end
    end else begin
      win_v <= in_valid && (col_cnt >= ADDR_WIDTH'(2));
      if (in_valid) begin
        col_cnt  <= (col_cnt == LAST_COL) ? '0 : col_cnt + ADDR_WIDTH'(1);
        win_col  <= col_cnt - ADDR_WIDTH'(1);
        for (int i = 0; i < 3; i++) begin
          win_l[i] <= win_c[i];
          win_c[i] <= win_r[i];
        end
        win_r[0] <= data_in_0;
        win_r[1] <= data_in_1;
        win_r[2] <= data_in_2;
      end
    end
  end

  // S1: horizontal [1 2 1] per row
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_col <= '0;
      for (int i = 0; i < 3; i++) row_sum[i] <= '0;
    end else begin
      s1_v   <= win_v;
      s1_col <= win_col;
      for (int i = 0; i < 3; i++)
        row_sum[i] <= RW'(win_l[i]) + (RW'(win_c[i]) << 1) + RW'(win_r[i]);
    end
  end

  always_comb begin
    sum_c = SW'(row_sum[0]) + (SW'(row_sum[1]) << 1) + SW'(row_sum[2]);
    rnd_c = PW'(sum_c) + PW'(8);
  end

  // S2: vertical [1 2 1] and rounding; data outputs hold between valid results
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_sum   <= '0;
      out_pix   <= '0;
      out_col   <= '0;
    end else begin
      out_valid <= s1_v;
      out_eol   <= s1_v && (s1_col == EOL_COL);
      if (s1_v) begin
        out_sum <= sum_c;
        out_pix <= DATA_WIDTH'(rnd_c >> 4);
        out_col <= s1_col;
      end
    end
  end

endmodule

// File: tb/tb_win3x3_filter.sv
// Directed bench for win3x3_filter: constant, ramp, full-scale, gapped, mid-line reset
// and back-to-back line scenarios with hand-derived expected results.
module tb_win3x3_filter;

  localparam int AW  = 7;
  localparam int DW  = 16;
  localparam int LEN = 100;
  localparam int BW  = 2 + AW + DW + 4 + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] d0, d1, d2;
  logic          in_valid;
  logic [DW+3:0] out_sum;
  logic [DW-1:0] out_pix;
  logic [AW-1:0] out_col;
  logic          out_eol;
  logic          out_valid;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  win3x3_filter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .clk(clk), .rst(rst),
    .data_in_0(d0), .data_in_1(d1), .data_in_2(d2), .in_valid(in_valid),
    .out_sum(out_sum), .out_pix(out_pix), .out_col(out_col),
    .out_eol(out_eol), .out_valid(out_valid)
  );

  // Drive one cycle of input and return 1 time unit after the sampling edge.
  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c);
    @(negedge clk);
    in_valid = v; d0 = a; d1 = b; d2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [BW-1:0] obs;
    rst = 1'b1;
    drive(1'b1, 16'd5, 16'd5, 16'd5);
    drive(1'b1, 16'd5, 16'd5, 16'd5);
    obs = {out_valid, out_eol, out_col, out_sum, out_pix};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  // One full line of a constant value on all rows; sum = 16v, pix = v.
  task automatic test_const(input logic [DW-1:0] v, input string name);
    logic [BW-1:0] obs, exp;
    int b;
    for (int k = 0; k < LEN + 2; k++) begin
      if (k < LEN) drive(1'b1, v, v, v);
      else         drive(1'b0, '0, '0, '0);
      b = k - 2;
      vectors++;
      if (b >= 2) begin
        obs = {out_valid, out_eol, out_col, out_sum, out_pix};
        exp = {1'b1, (b == LEN - 1), AW'(b - 1), ({4'b0, v} << 4), v};
      end else begin
        obs = BW'({out_valid, out_eol});
        exp = '0;
      end
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL %s k=%0d got %h want %h", name, k, obs, exp);
      end
    end
  endtask

  // Ramp top=j, mid=128+j, bot=256+j; centre c gives sum 16c+2048, pix c+128.
  task automatic test_ramp(input bit gapped);
    int beat_of [0:2*LEN+1];
    logic [BW-1:0] obs, exp;
    logic [DW+3:0] last_sum;
    logic [DW-1:0] last_pix;
    bit have_last;
    bit v;
    int j, b, total, c;
    j = 0;
    have_last = 1'b0;
    last_sum = '0;
    last_pix = '0;
    total = gapped ? 2 * LEN + 1 : LEN + 2;
    for (int k = 0; k < total; k++) begin
      v = gapped ? ((k % 2 == 0) && (k < 2 * LEN)) : (k < LEN);
      if (v) begin
        drive(1'b1, DW'(j), DW'(128 + j), DW'(256 + j));
        beat_of[k] = j;
        j++;
      end else begin
        drive(1'b0, '0, '0, '0);
        beat_of[k] = -1;
      end
      if (k >= 2) begin
        b = beat_of[k-2];
        vectors++;
        if (b >= 2) begin
          c = b - 1;
          last_sum = (DW+4)'(16 * c + 2048);
          last_pix = DW'(c + 128);
          have_last = 1'b1;
          obs = {out_valid, out_eol, out_col, out_sum, out_pix};
          exp = {1'b1, (c == LEN - 2), AW'(c), last_sum, last_pix};
        end else if (have_last) begin
          obs = BW'({out_valid, out_eol, out_sum, out_pix});
          exp = BW'({2'b00, last_sum, last_pix});
        end else begin
          obs = BW'({out_valid, out_eol});
          exp = '0;
        end
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL ramp%s k=%0d got %h want %h", gapped ? "_gapped" : "", k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [BW-1:0] obs;
    for (int j = 0; j <= 50; j++)
      drive(1'b1, DW'(j), DW'(128 + j), DW'(256 + j));
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    obs = {out_valid, out_eol, out_col, out_sum, out_pix};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_clear got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, '0, '0);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_flush k=%0d got out_valid=%b want 0", k, out_valid);
      end
    end
    test_const(16'd50, "post_reset_line");
  endtask

  // Line A const 10 followed immediately by line B const 200.
  task automatic test_back_to_back();
    logic [BW-1:0] obs, exp;
    logic [DW-1:0] val;
    int b, col;
    for (int k = 0; k < 2 * LEN + 2; k++) begin
      if (k < LEN)          drive(1'b1, 16'd10, 16'd10, 16'd10);
      else if (k < 2 * LEN) drive(1'b1, 16'd200, 16'd200, 16'd200);
      else                  drive(1'b0, '0, '0, '0);
      b = k - 2;
      if (b >= 0) begin
        col = b % LEN;
        val = (b < LEN) ? 16'd10 : 16'd200;
        vectors++;
        if (col >= 2) begin
          obs = {out_valid, out_eol, out_col, out_sum, out_pix};
          exp = {1'b1, (col == LEN - 1), AW'(col - 1), ({4'b0, val} << 4), val};
        end else begin
          obs = BW'({out_valid, out_eol});
          exp = '0;
        end
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL back_to_back k=%0d got %h want %h", k, obs, exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    test_reset();
    test_const(16'd100, "const100");
    test_ramp(1'b0);
    test_const(16'hFFFF, "full_scale");
    test_ramp(1'b1);
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
